// File: rtl/mem_stage_if.sv
// EXE -> MEM handshake bus: one instruction offered per cycle, accepted on valid & allowin.
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_mem_re;
    logic        es_mem_we;
    logic [4:0]  es_ld_op;
    logic        es_req_sent;
    logic        es_ex;

    modport master (
        output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we,
               es_mem_re, es_mem_we, es_ld_op, es_req_sent, es_ex,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we,
               es_mem_re, es_mem_we, es_ld_op, es_req_sent, es_ex,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for data-SRAM responses, extracts load data, forwards to WB,
// and discards late responses belonging to requests orphaned by a flush.
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  es,
    input  logic        ws_allowin,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        flush,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_ex,
    output logic        ms_fwd_we,
    output logic        ms_fwd_blocking,
    output logic        out_ms_valid
);

    localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

    logic                ms_valid_q, ms_valid_d;
    logic                wait_resp_q, wait_resp_d;
    logic                buf_valid_q, buf_valid_d;
    logic [31:0]         rbuf_q, rbuf_d;
    logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         result_q, result_d;
    logic [4:0]          dest_q, dest_d;
    logic                gr_we_q, gr_we_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [4:0]          ld_op_q, ld_op_d;
    logic                ex_q, ex_d;

    logic                data_ok_live;
    logic                ms_data_ready;
    logic                ms_ready_go;
    logic                accept;
    logic                inc_own;
    logic                inc_offered;
    logic                dec_orphan;
    logic [CANCEL_W+1:0] cancel_sum;
    logic [31:0]         load_src;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;

    // A response only belongs to the current instruction once all orphaned ones have drained.
    assign data_ok_live   = data_sram_data_ok & (cancel_cnt_q == '0);
    assign ms_data_ready  = ~wait_resp_q | data_ok_live;
    assign ms_ex          = ms_valid_q & ex_q;
    assign ms_ready_go    = ms_ex | ms_data_ready;
    assign es.ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign accept         = es.es_to_ms_valid & es.ms_allowin & ~flush;

    assign ms_to_ws_valid  = ms_valid_q & ms_ready_go & ~flush;
    assign out_ms_valid    = ms_valid_q;
    assign ms_pc           = pc_q;
    assign ms_dest         = dest_q;
    assign ms_gr_we        = ms_valid_q & gr_we_q & ~ex_q;
    assign ms_fwd_we       = ms_gr_we & (dest_q != 5'd0);
    assign ms_fwd_blocking = ms_fwd_we & mem_re_q & ~ms_data_ready & ~buf_valid_q;

    assign inc_own     = flush & wait_resp_q & ~data_ok_live;
    assign inc_offered = flush & es.es_to_ms_valid & es.es_req_sent & ~es.es_ex;
    assign dec_orphan  = data_sram_data_ok & (cancel_cnt_q != '0);

    always_comb begin
        cancel_sum   = {2'b00, cancel_cnt_q}
                     + {{(CANCEL_W+1){1'b0}}, inc_own}
                     + {{(CANCEL_W+1){1'b0}}, inc_offered}
                     - {{(CANCEL_W+1){1'b0}}, dec_orphan};
        cancel_cnt_d = cancel_sum[CANCEL_W-1:0];
        if (cancel_sum > {2'b00, CANCEL_MAX}) begin
            cancel_cnt_d = CANCEL_MAX;
        end
    end

    always_comb begin
        ms_valid_d  = ms_valid_q;
        wait_resp_d = wait_resp_q;
        buf_valid_d = buf_valid_q;
        rbuf_d      = rbuf_q;
        pc_d        = pc_q;
        result_d    = result_q;
        dest_d      = dest_q;
        gr_we_d     = gr_we_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        ld_op_d     = ld_op_q;
        ex_d        = ex_q;

        if (flush) begin
            ms_valid_d  = 1'b0;
            wait_resp_d = 1'b0;
            buf_valid_d = 1'b0;
        end else if (es.ms_allowin) begin
            ms_valid_d  = es.es_to_ms_valid;
            wait_resp_d = 1'b0;
            buf_valid_d = 1'b0;
            if (accept) begin
                wait_resp_d = es.es_req_sent & ~es.es_ex;
                pc_d        = es.es_pc;
                result_d    = es.es_result;
                dest_d      = es.es_dest;
                gr_we_d     = es.es_gr_we;
                mem_re_d    = es.es_mem_re;
                mem_we_d    = es.es_mem_we;
                ld_op_d     = es.es_ld_op;
                ex_d        = es.es_ex;
            end
        end else if (wait_resp_q & data_ok_live) begin
            // WB is stalled: park the response so it survives rdata changing.
            wait_resp_d = 1'b0;
            buf_valid_d = 1'b1;
            rbuf_d      = data_sram_rdata;
        end
    end

    always_comb begin
        load_src = buf_valid_q ? rbuf_q : data_sram_rdata;
        case (result_q[1:0])
            2'd0:    ld_byte = load_src[7:0];
            2'd1:    ld_byte = load_src[15:8];
            2'd2:    ld_byte = load_src[23:16];
            default: ld_byte = load_src[31:24];
        endcase
        ld_half = result_q[1] ? load_src[31:16] : load_src[15:0];

        ms_final_result = result_q;
        if (mem_re_q & ~mem_we_q & ~ex_q) begin
            case (ld_op_q)
                5'b10000: ms_final_result = {{24{ld_byte[7]}}, ld_byte};
                5'b01000: ms_final_result = {24'd0, ld_byte};
                5'b00100: ms_final_result = {{16{ld_half[15]}}, ld_half};
                5'b00010: ms_final_result = {16'd0, ld_half};
                5'b00001: ms_final_result = load_src;
                default:  ms_final_result = result_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid_q   <= 1'b0;
            wait_resp_q  <= 1'b0;
            buf_valid_q  <= 1'b0;
            rbuf_q       <= '0;
            cancel_cnt_q <= '0;
            pc_q         <= '0;
            result_q     <= '0;
            dest_q       <= '0;
            gr_we_q      <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ld_op_q      <= '0;
            ex_q         <= 1'b0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            wait_resp_q  <= wait_resp_d;
            buf_valid_q  <= buf_valid_d;
            rbuf_q       <= rbuf_d;
            cancel_cnt_q <= cancel_cnt_d;
            pc_q         <= pc_d;
            result_q     <= result_d;
            dest_q       <= dest_d;
            gr_we_q      <= gr_we_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            ld_op_q      <= ld_op_d;
            ex_q         <= ex_d;
        end
    end

endmodule
